// File: rtl/apb_dual_master_arb.sv
// ---------------------------------------------------------------------------
// apb_dual_master_arb
//
// APB master controller for two local requesters. It arbitrates round-robin
// between them and runs the APB SETUP/ACCESS sequence toward two byte-wide
// slaves. Bit 8 of the request address selects the slave (0 = slave1,
// 1 = slave2), and bits 7:0 drive PADDR.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : if PREADY stays low for TIMEOUT wait cycles, the access is
//               aborted and completed with errN = 1 and rdataN = 0 on a read.
//   undefined : the controller waits in ACCESS indefinitely, and err0/err1
//               are tied low.
//
// Parameters
//   TIMEOUT            wait-cycle limit, 1..255 (used with APB_TIMEOUT_EN)
//
// Ports
//   PCLK, PRESET       clock and synchronous active-high reset
//   reqN, wrN          request (held until ackN) and direction (1 = write)
//   addrN, wdataN      9-bit address with slave select, 8-bit write data
//   ackN, errN         one-cycle completion pulse and timeout flag
//   rdataN             read data, held until the next ack to that requester
//   PSEL1, PSEL2       slave selects
//   PENABLE, PWRITE    APB phase and direction
//   PADDR, PWDATA      APB address and write data
//   PREADYx, PRDATAx   per-slave ready and read data
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; grant an eligible requester and latch its request
// SETUP  | PSELx high, PENABLE low; always lasts one cycle
// ACCESS | PSELx and PENABLE high; wait for the selected PREADY
// ---------------------------------------------------------------------------
module apb_dual_master_arb #(
    parameter int TIMEOUT = 15
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [8:0] addr0,
    input  logic [8:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic       PREADY1,
    input  logic       PREADY2,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("apb_dual_master_arb: TIMEOUT must be within 1..255");
    end

    state_t     state;
    logic       last_grant;
    logic       cur;          // requester owning the transfer in flight
    logic       elig0;
    logic       elig1;
    logic       grant1;
    logic       sel_ready;
    logic [7:0] sel_prdata;
    logic       done;
    logic [7:0] done_rdata;

    // A requester whose ack is visible this cycle still has req high, so it
    // is masked to keep it from being granted a second time.
    assign elig0  = req0 & ~ack0;
    assign elig1  = req1 & ~ack1;
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    // PSEL2 is registered and stable across ACCESS, so it can pick the slave.
    assign sel_ready  = PSEL2 ? PREADY2 : PREADY1;
    assign sel_prdata = PSEL2 ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [7:0] wait_cnt;
    logic       timed_out;

    // wait_cnt is 0 in the first ACCESS cycle, so the abort happens in
    // ACCESS cycle TIMEOUT+1.
    assign timed_out  = ~sel_ready & (wait_cnt == TIMEOUT_CNT);
    assign done       = sel_ready | timed_out;
    assign done_rdata = sel_ready ? sel_prdata : 8'h00;
`else
    assign done       = sel_ready;
    assign done_rdata = sel_prdata;
    assign err0       = 1'b0;
    assign err1       = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
            PSEL1      <= 1'b0;
            PSEL2      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= 8'h00;
            PWDATA     <= 8'h00;
`ifdef APB_TIMEOUT_EN
            wait_cnt   <= 8'h00;
            err0       <= 1'b0;
            err1       <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        cur        <= grant1;
                        last_grant <= grant1;
                        PWRITE     <= grant1 ? wr1 : wr0;
                        PADDR      <= grant1 ? addr1[7:0] : addr0[7:0];
                        PWDATA     <= grant1 ? wdata1 : wdata0;
                        PSEL1      <= grant1 ? ~addr1[8] : ~addr0[8];
                        PSEL2      <= grant1 ? addr1[8] : addr0[8];
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= 8'h00;
`endif
                end
                ACCESS: begin
                    if (done) begin
                        PSEL1   <= 1'b0;
                        PSEL2   <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                        if (cur) begin
                            ack1 <= 1'b1;
                            if (!PWRITE) rdata1 <= done_rdata;
`ifdef APB_TIMEOUT_EN
                            err1 <= ~sel_ready;
`endif
                        end else begin
                            ack0 <= 1'b1;
                            if (!PWRITE) rdata0 <= done_rdata;
`ifdef APB_TIMEOUT_EN
                            err0 <= ~sel_ready;
`endif
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_dual_master_arb.md
# apb_dual_master_arb

Two-requester APB master controller that arbitrates between two local requesters and sequences APB SETUP/ACCESS phases toward the two byte-wide memory slaves, slave1 and slave2. Each slave has 64 entries. It sits between the system-side request logic and the shared APB bus. It owns PSEL decode, PENABLE sequencing, round-robin fairness and optional wait-state timeout.

## Interface
- TIMEOUT, 15: maximum ACCESS cycles with PREADY low before abort; legal range 1..255. Used only with APB_TIMEOUT_EN.
- PCLK  in  1  APB clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req0, req1  in  1  transfer request; held high until the matching ack.
- wr0, wr1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  9  bit 8 is slave select (0 = slave1, 1 = slave2); bits 7:0 drive PADDR.
- wdata0, wdata1  in  8  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  timeout flag; valid with ack.
- rdata0, rdata1  out  8  read data; valid with ack and held until the next ack to that requester.
- PSEL1, PSEL2  out  1  slave selects.
- PENABLE, PWRITE  out  1  APB control.
- PADDR, PWDATA  out  8  APB address and write data.
- PREADY1, PREADY2  in  1  per-slave ready.
- PRDATA1, PRDATA2  in  8  per-slave read data.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE**
  - Eligible requester: reqN=1 and ackN=0 in the same cycle. This masks the requester being acked.
  - If none is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the requester other than last_grant.
  - On grant, latch wr, addr and wdata into the transfer registers, update last_grant, and go to SETUP.
- **SETUP**
  - Drive PSELx from addr[8]; exactly one PSEL is high.
  - PENABLE=0; PWRITE, PADDR and PWDATA come from the latched values.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - PSELx and PENABLE are high; PWRITE, PADDR and PWDATA are unchanged from SETUP.
  - Sampled ready is PREADY of the selected slave; the other slave's PREADY is ignored.
  - Ready = 1: capture the selected PRDATA into rdataN on a read (rdataN is unchanged on a write), set ackN=1 and errN=0, go to IDLE.
  - Ready = 0: stay in ACCESS and increment the wait counter (8-bit, cleared in SETUP).
- After ACCESS, the next state is always IDLE. Back-to-back transfers are therefore at least three cycles apart.
- In IDLE, PSEL1, PSEL2 and PENABLE are 0. PADDR, PWDATA and PWRITE hold their last values.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so req0 wins the first tie.
  - All outputs are 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, ackN, errN, rdataN.
  - Wait counter = 0.
- Reset mid-transfer: on the next edge everything returns to the reset values. No ack is issued for the aborted transfer, and the requester must re-request.

## Timing
- The grant decision uses requests sampled at the IDLE edge.
- SETUP is exactly one cycle.
- ACCESS lasts 1 + W cycles, where W is the number of cycles the selected PREADY is low.
- ackN is registered and asserted in the IDLE cycle that follows the ready ACCESS edge. It is high for exactly one cycle.
- Zero-wait latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → ack at cycle 3.
- Write data is committed in the slave during ACCESS.
- Read data is sampled at the edge ending ACCESS.
- A requester sees ack, then drops or changes its req in the next cycle.

## Configuration
- APB_TIMEOUT_EN defined:
  - When the wait counter reaches TIMEOUT with ready still 0, force completion.
  - Set ackN=1 and errN=1, set rdataN=0 on a read, deassert PSEL and PENABLE, and go to IDLE.
  - Total ACCESS length on timeout is TIMEOUT+1 cycles.
- APB_TIMEOUT_EN undefined:
  - No counter and no timeout logic; the controller waits in ACCESS indefinitely.
  - err0 and err1 are tied to 0.

## Test plan
- Write then read, zero wait:
  - Stimulus: req0 writes addr0=0x005, wdata0=0xA5, then req0 reads 0x005.
  - Response: PSEL1 only; ack0 at cycle 3 of each transfer; rdata0=0xA5; err0=0.
- Slave select:
  - Stimulus: req1 writes addr1=0x10A, data 0x3C, then reads 0x10A.
  - Response: PSEL2 only; PADDR=0x0A; rdata1=0x3C; PSEL1 never asserted.
- Round-robin:
  - Stimulus: req0 and req1 held high continuously from reset for four transfers.
  - Response: grant order 0,1,0,1; each ack arrives 3 cycles after its grant; no requester is granted twice in a row.
- Wait states:
  - Stimulus: selected PREADY held low for 4 ACCESS cycles on a read of 0x020.
  - Response: ACCESS lasts 5 cycles; PADDR and PSEL are stable throughout; ack is one cycle.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=15):
  - Stimulus: PREADY tied low.
  - Response: ack0=1 and err0=1 after 16 ACCESS cycles; rdata0=0x00; the next request proceeds normally.
- Reset mid-ACCESS:
  - Stimulus: PRESET=1 for one cycle during the 2nd wait cycle.
  - Response: next cycle all outputs are 0 and state is IDLE; no ack; a re-issued req0 completes normally.
